step_counter: RTL and testbench

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/booth_pkg.sv | 23 ++
 rtl/step_counter.sv | 115 +++++++++++
 tb/tb_step_counter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// booth_pkg
//
// Definitions shared by step_counter and anything that instantiates it:
//   - DefaultWidth / DefaultSteps : default counter width and run length
//   - step_state_e                : run-control state encoding
// ---------------------------------------------------------------------------
package booth_pkg;

    // Default geometry: a 5-bit counter walking 16 steps per run.
    localparam int DefaultWidth = 5;
    localparam int DefaultSteps = 16;

    // IDLE waits for start, RUN walks the count, DONE is the one-cycle
    // completion state that drives the done pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } step_state_e;

endpackage

// File: rtl/step_counter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// step_counter
//
// Walks an index through Steps positions, one position per en_PP pulse,
// either upward (0 .. Steps-1) or downward (Steps-1 .. 0), and signals
// completion with a single-cycle done pulse.
//
// Parameters
//   Width : bit width of the step index
//   Steps : positions per run, legal range 1 .. 2**Width
//
// Ports
//   clk    in   sole clock, all state changes on the rising edge
//   reset  in   asynchronous active-high reset
//   start  in   begin or restart a run (dir is sampled with it)
//   abort  in   terminate a run without completion; wins over start
//   dir    in   0 = count up, 1 = count down
//   en_PP  in   advance one step while running
//   out    out  current step index
//   busy   out  high while a run is in progress
//   last   out  high while busy and out sits at the terminal value
//   done   out  single-cycle completion pulse
// ---------------------------------------------------------------------------
module step_counter
    import booth_pkg::*;
#(
    parameter int Width = DefaultWidth,
    parameter int Steps = DefaultSteps
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic             en_PP,
    output logic [Width-1:0] out,
    output logic             busy,
    output logic             last,
    output logic             done
);

    // Reject illegal geometry while elaborating rather than building a
    // counter whose terminal value cannot be represented.
    if (Width < 1 || Steps < 1 || Steps > (1 << Width)) begin : g_param_check
        $error("step_counter: Steps must lie in 1 .. 2**Width");
    end

    // Terminal value of an upward run; the downward terminal is zero.
    localparam logic [Width-1:0] TermUp  = Width'(Steps - 1);
    localparam logic [Width-1:0] StepOne = Width'(1);

    step_state_e      state;
    logic [Width-1:0] count;
    logic             dir_q;

    logic [Width-1:0] term_value;
    logic             at_term;

    // The terminal comparison is taken against the registered count, so the
    // step that would overflow or underflow is never taken: reaching the
    // terminal value finishes the run instead of advancing.
    assign term_value = dir_q ? '0 : TermUp;
    assign at_term    = (count == term_value);

    // Every output is decoded purely from registered state, so no input can
    // reach an output within the same cycle.
    assign out  = count;
    assign busy = (state == RUN);
    assign last = (state == RUN) && at_term;
    assign done = (state == DONE);

    // Run control and counter. Priority is reset, then abort, then start,
    // then the normal per-state behaviour. start is accepted in every state,
    // which gives restart-in-RUN and restart-from-DONE for free; en_PP in the
    // start cycle is deliberately ignored because the reload takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            dir_q <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            count <= '0;
        end else if (start) begin
            state <= RUN;
            count <= dir ? TermUp : '0;
            dir_q <= dir;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RUN: begin
                    if (en_PP) begin
                        if (at_term) begin
                            state <= DONE;
                        end else if (dir_q) begin
                            count <= count - StepOne;
                        end else begin
                            count <= count + StepOne;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_counter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_step_counter
//
// Drives a 16-step and a 1-step step_counter with identical stimulus.
// A reference model describes each run as "how many steps have been taken"
// and derives the visible index from that; the driver pushes the expected
// outputs into a queue and an independent monitor compares after each edge.
// ---------------------------------------------------------------------------
module tb_step_counter;

    localparam int Width     = 5;
    localparam int StepsMain = 16;
    localparam int StepsOne  = 1;

    typedef struct {
        bit running;
        int taken;
        bit mdir;
        int idle_out;
        bit pulse;
    } model_t;

    typedef struct {
        int out;
        bit busy;
        bit last;
        bit done;
    } expect_t;

    typedef struct {
        expect_t a;
        expect_t b;
    } pair_t;

    logic clk;
    logic reset;
    logic start;
    logic abort;
    logic dir;
    logic en_PP;

    logic [Width-1:0] out_a;
    logic             busy_a;
    logic             last_a;
    logic             done_a;
    logic [Width-1:0] out_b;
    logic             busy_b;
    logic             last_b;
    logic             done_b;

    int checks = 0;
    int errors = 0;

    pair_t  sb_q[$];
    model_t m_a;
    model_t m_b;

    step_counter #(.Width(Width), .Steps(StepsMain)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .dir   (dir),
        .en_PP (en_PP),
        .out   (out_a),
        .busy  (busy_a),
        .last  (last_a),
        .done  (done_a)
    );

    step_counter #(.Width(Width), .Steps(StepsOne)) dut_one (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .dir   (dir),
        .en_PP (en_PP),
        .out   (out_b),
        .busy  (busy_b),
        .last  (last_b),
        .done  (done_b)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the stimulus.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Position of a run after 'taken' steps, in the run's direction.
    function automatic int run_pos(model_t m, int steps);
        return m.mdir ? (steps - 1 - m.taken) : m.taken;
    endfunction

    // One clock edge of the reference behaviour.
    function automatic model_t model_step(model_t m, bit rst, bit st, bit ab,
                                          bit d, bit en, int steps);
        model_t n = m;
        n.pulse = 1'b0;
        if (rst) begin
            n.running  = 1'b0;
            n.taken    = 0;
            n.mdir     = 1'b0;
            n.idle_out = 0;
        end else if (ab) begin
            n.running  = 1'b0;
            n.idle_out = 0;
        end else if (st) begin
            n.running = 1'b1;
            n.taken   = 0;
            n.mdir    = d;
        end else if (m.running && en) begin
            if (m.taken == steps - 1) begin
                n.running  = 1'b0;
                n.idle_out = run_pos(m, steps);
                n.pulse    = 1'b1;
            end else begin
                n.taken = m.taken + 1;
            end
        end
        return n;
    endfunction

    function automatic expect_t model_view(model_t m, int steps);
        expect_t e;
        e.out  = m.running ? run_pos(m, steps) : m.idle_out;
        e.busy = m.running;
        e.last = m.running && (m.taken == steps - 1);
        e.done = m.pulse;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue what the
    // outputs must look like after the following rising edge.
    task automatic applyStimulus(input bit rst, input bit st, input bit ab,
                                 input bit d, input bit en);
        pair_t p;
        @(negedge clk);
        reset = rst;
        start = st;
        abort = ab;
        dir   = d;
        en_PP = en;
        m_a = model_step(m_a, rst, st, ab, d, en, StepsMain);
        m_b = model_step(m_b, rst, st, ab, d, en, StepsOne);
        p.a = model_view(m_a, StepsMain);
        p.b = model_view(m_b, StepsOne);
        sb_q.push_back(p);
    endtask

    // Monitor: after each rising edge compare both instances against the
    // oldest queued expectation.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                p = sb_q.pop_front();
                checkOutput("out",    32'(out_a),  32'(p.a.out));
                checkOutput("busy",   32'(busy_a), 32'(p.a.busy));
                checkOutput("last",   32'(last_a), 32'(p.a.last));
                checkOutput("done",   32'(done_a), 32'(p.a.done));
                checkOutput("out1",   32'(out_b),  32'(p.b.out));
                checkOutput("busy1",  32'(busy_b), 32'(p.b.busy));
                checkOutput("last1",  32'(last_b), 32'(p.b.last));
                checkOutput("done1",  32'(done_b), 32'(p.b.done));
            end
        end
    end

    initial begin
        bit st;
        bit ab;
        bit rs;
        bit d;
        bit en;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        dir   = 1'b0;
        en_PP = 1'b0;
        m_a   = '{default: 0};
        m_b   = '{default: 0};

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] up run, en_PP held high");
        applyStimulus(0, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] down run with gaps");
        applyStimulus(0, 1, 0, 1, 0);
        for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 0, (i % 2) == 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] abort together with start at out=7");
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] restart at out=9, then restart from DONE");
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] asynchronous reset at out=5");
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_out",  32'(out_a),  32'd0);
        checkOutput("async_busy", 32'(busy_a), 32'd0);
        checkOutput("async_last", 32'(last_a), 32'd0);
        checkOutput("async_done", 32'(done_a), 32'd0);
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2500; i++) begin
            st = ($urandom_range(0, 99) < 3);
            ab = ($urandom_range(0, 199) < 3);
            rs = ($urandom_range(0, 599) == 0);
            d  = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 99) < 75);
            applyStimulus(rs, st, ab, d, en);
        end

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
